dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single SRAM-like dcache port between two requesters: the CPU data port and the store-buffer drain port.
- Sits between the store buffer and the dcache.
- Tracks in-order outstanding transactions so each data_ok and rdata return to the requester that issued the request.
- Prevents store-drain starvation with a bounded-wait counter and an urgent override.

Parameters:
- MAX_OUTSTANDING, 4: maximum accepted-but-not-completed transactions. Power of two, 2..8.
- STARVE_LIMIT, 8: consecutive CPU wins while a drain request is pending before the drain port is forced ahead.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cpu_data_req  in  1  CPU request valid
- cpu_data_wr  in  1  CPU write (1) / read (0)
- cpu_data_size  in  2  CPU access size
- cpu_data_addr  in  32  CPU address
- cpu_data_wdata  in  32  CPU write data
- cpu_data_wstrb  in  4  CPU byte strobes
- cpu_data_rdata  out  32  read data to CPU
- cpu_data_addr_ok  out  1  CPU request accepted
- cpu_data_data_ok  out  1  CPU transaction complete
- sb_data_req  in  1  drain request valid (always a write, size 2'd2)
- sb_data_addr  in  32  drain address
- sb_data_wdata  in  32  drain data
- sb_data_wstrb  in  4  drain strobes
- sb_urgent  in  1  store buffer full; drain gets priority
- sb_data_addr_ok  out  1  drain accepted
- sb_data_data_ok  out  1  drain write complete
- dcache_data_req  out  1  request to dcache
- dcache_data_wr  out  1  write flag to dcache
- dcache_data_size  out  2  size to dcache
- dcache_data_addr  out  32  address to dcache
- dcache_data_wdata  out  32  write data to dcache
- dcache_data_wstrb  out  4  strobes to dcache
- dcache_data_rdata  in  32  read data from dcache
- dcache_data_addr_ok  in  1  dcache accepted the request
- dcache_data_data_ok  in  1  dcache completed the head transaction

Behaviour:
- Owner FIFO:
  - Depth MAX_OUTSTANDING, 1-bit tag per entry (0 = cpu, 1 = sb), with a count register.
  - Push the granted owner on dcache_data_req && dcache_data_addr_ok.
  - Pop the head on dcache_data_data_ok.
  - Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo depth.
- Issue gating: when count == MAX_OUTSTANDING, dcache_data_req = 0 and both addr_ok outputs = 0, unless a pop occurs in the same cycle. A same-cycle pop does not free a slot; issue stays blocked for that cycle.
- Grant selection (combinational), only when not locked:
  - sb wins if sb_data_req && (sb_urgent || starve_cnt == STARVE_LIMIT || !cpu_data_req).
  - Otherwise cpu wins if cpu_data_req.
- Lock:
  - A registered lock plus lock_owner is set when the granted request is presented and dcache_data_addr_ok = 0.
  - While locked, the grant is held to lock_owner and the dcache_data_* request fields come from that requester.
  - The lock clears on addr_ok.
  - Requesters hold their request stable until addr_ok.
- Mux: the dcache_data_* request fields follow the granted requester. For sb, wr = 1 and size = 2'd2. With no grant, dcache_data_req = 0 and the other fields are don't-care, driven 0.
- addr_ok routing: cpu_data_addr_ok / sb_data_addr_ok = dcache_data_addr_ok && owner match && issue allowed.
- data_ok routing:
  - On dcache_data_data_ok, assert the data_ok of the FIFO head owner for that cycle only.
  - cpu_data_rdata = dcache_data_rdata passthrough.
  - data_ok with an empty FIFO is ignored (not routed); verification flags it as an error.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 per cycle when cpu is accepted while sb_data_req = 1.
  - Clears to 0 on sb accept or whenever sb_data_req = 0.
  - Saturates at STARVE_LIMIT.
- Latency: zero added cycles. Request and response paths are combinational through the arbiter.
- Reset (asynchronous, resetn = 0): FIFO empty, count = 0, lock = 0, starve_cnt = 0. All addr_ok/data_ok/req outputs are 0 and rdata is passthrough. Reset mid-transaction drops outstanding tags; the dcache is reset on the same resetn.

Test Plan:
- Only cpu read to 0x1000, dcache addr_ok next cycle, data_ok 2 cycles later with rdata 0xDEADBEEF -> cpu_data_addr_ok and cpu_data_data_ok each pulse once, cpu_data_rdata = 0xDEADBEEF, sb outputs stay 0.
- cpu and sb both request continuously, dcache always ready -> cpu wins 8 consecutive accepts, then sb accepted exactly once, starve_cnt back to 0, pattern repeats.
- sb_urgent = 1 with both requesting -> sb granted the same cycle. Tags ordered sb, cpu; data_ok pulses go to sb first, then cpu.
- cpu request, dcache holds addr_ok = 0 for 3 cycles, sb_urgent rises in cycle 2 -> dcache_data_addr remains the cpu address until accepted; sb granted afterwards.
- 4 accepts with no data_ok -> 5th request blocked (no addr_ok). One data_ok frees a slot and the next cycle the request is accepted. Push/pop in the same cycle at count = 2 keeps count = 2.
- resetn low with 3 outstanding -> all outputs 0 asynchronously. After release, a new cpu read completes normally with correct routing.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single dcache request port between the CPU data port and the
// store-buffer drain port, routing in-order completions back to the issuing side.
module dcache_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    input  logic [3:0]  cpu_data_wstrb,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    input  logic        sb_data_req,
    input  logic [31:0] sb_data_addr,
    input  logic [31:0] sb_data_wdata,
    input  logic [3:0]  sb_data_wstrb,
    input  logic        sb_urgent,
    output logic        sb_data_addr_ok,
    output logic        sb_data_data_ok,
    output logic        dcache_data_req,
    output logic        dcache_data_wr,
    output logic [1:0]  dcache_data_size,
    output logic [31:0] dcache_data_addr,
    output logic [31:0] dcache_data_wdata,
    output logic [3:0]  dcache_data_wstrb,
    input  logic [31:0] dcache_data_rdata,
    input  logic        dcache_data_addr_ok,
    input  logic        dcache_data_data_ok
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ZERO  = STV_W'(0);
    localparam logic [STV_W-1:0] STV_ONE   = STV_W'(1);
    localparam logic             OWNER_CPU = 1'b0;
    localparam logic             OWNER_SB  = 1'b1;

    logic [MAX_OUTSTANDING-1:0] tag_mem_r;
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       lock_r;
    logic                       lock_owner_r;
    logic [STV_W-1:0]           starve_cnt_r;

    logic grant_valid_s;
    logic grant_owner_s;
    logic issue_s;
    logic accept_s;
    logic pop_s;
    logic head_owner_s;

    // Grant selection; a lock pins the grant to the requester left waiting on addr_ok.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_owner_s = OWNER_CPU;
        if (lock_r) begin
            grant_owner_s = lock_owner_r;
            grant_valid_s = lock_owner_r ? sb_data_req : cpu_data_req;
        end else if (sb_data_req && (sb_urgent || (starve_cnt_r == STV_MAX) || !cpu_data_req)) begin
            grant_valid_s = 1'b1;
            grant_owner_s = OWNER_SB;
        end else if (cpu_data_req) begin
            grant_valid_s = 1'b1;
            grant_owner_s = OWNER_CPU;
        end else begin
            grant_valid_s = 1'b0;
            grant_owner_s = OWNER_CPU;
        end
    end

    // A full owner FIFO blocks issue even if a completion pops in the same cycle.
    assign issue_s      = resetn && grant_valid_s && (count_r != CNT_FULL);
    assign accept_s     = issue_s && dcache_data_addr_ok;
    assign pop_s        = resetn && dcache_data_data_ok && (count_r != CNT_ZERO);
    assign head_owner_s = tag_mem_r[rd_ptr_r];

    // Request field mux toward the dcache; idle fields are driven to zero.
    always_comb begin
        dcache_data_req   = 1'b0;
        dcache_data_wr    = 1'b0;
        dcache_data_size  = 2'd0;
        dcache_data_addr  = 32'd0;
        dcache_data_wdata = 32'd0;
        dcache_data_wstrb = 4'd0;
        if (issue_s) begin
            dcache_data_req = 1'b1;
            case (grant_owner_s)
                OWNER_SB: begin
                    dcache_data_wr    = 1'b1;
                    dcache_data_size  = 2'd2;
                    dcache_data_addr  = sb_data_addr;
                    dcache_data_wdata = sb_data_wdata;
                    dcache_data_wstrb = sb_data_wstrb;
                end
                default: begin
                    dcache_data_wr    = cpu_data_wr;
                    dcache_data_size  = cpu_data_size;
                    dcache_data_addr  = cpu_data_addr;
                    dcache_data_wdata = cpu_data_wdata;
                    dcache_data_wstrb = cpu_data_wstrb;
                end
            endcase
        end else begin
            dcache_data_req = 1'b0;
        end
    end

    assign cpu_data_addr_ok = accept_s && (grant_owner_s == OWNER_CPU);
    assign sb_data_addr_ok  = accept_s && (grant_owner_s == OWNER_SB);
    assign cpu_data_data_ok = pop_s && (head_owner_s == OWNER_CPU);
    assign sb_data_data_ok  = pop_s && (head_owner_s == OWNER_SB);
    assign cpu_data_rdata   = dcache_data_rdata;

    // Owner FIFO: push granted owner on accept, pop head on completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_mem_r <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_r  <= PTR_W'(0);
            rd_ptr_r  <= PTR_W'(0);
            count_r   <= CNT_ZERO;
        end else begin
            if (accept_s) begin
                tag_mem_r[wr_ptr_r] <= grant_owner_s;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Lock tracking: hold the presented request until the dcache accepts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_r       <= 1'b0;
            lock_owner_r <= OWNER_CPU;
        end else if (accept_s) begin
            lock_r <= 1'b0;
        end else if (issue_s) begin
            lock_r       <= 1'b1;
            lock_owner_r <= grant_owner_s;
        end
    end

    // Starvation counter: CPU wins while the drain waits, saturating at the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_r <= STV_ZERO;
        end else if (!sb_data_req) begin
            starve_cnt_r <= STV_ZERO;
        end else if (accept_s && (grant_owner_s == OWNER_SB)) begin
            starve_cnt_r <= STV_ZERO;
        end else if (accept_s && (starve_cnt_r != STV_MAX)) begin
            starve_cnt_r <= starve_cnt_r + STV_ONE;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter; expected completion owners flow through
// a scoreboard queue filled at accept time and drained on each data_ok.
module tb_dcache_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_data_req, cpu_data_wr;
    logic [1:0]  cpu_data_size;
    logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
    logic [3:0]  cpu_data_wstrb;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        sb_data_req, sb_urgent, sb_data_addr_ok, sb_data_data_ok;
    logic [31:0] sb_data_addr, sb_data_wdata;
    logic [3:0]  sb_data_wstrb;
    logic        dcache_data_req, dcache_data_wr;
    logic [1:0]  dcache_data_size;
    logic [31:0] dcache_data_addr, dcache_data_wdata, dcache_data_rdata;
    logic [3:0]  dcache_data_wstrb;
    logic        dcache_data_addr_ok, dcache_data_data_ok;

    int   check_cnt = 0;
    int   pass_cnt  = 0;
    logic exp_owner_q[$];

    always #5 clk = ~clk;

    dcache_port_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
        .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
        .cpu_data_wdata(cpu_data_wdata), .cpu_data_wstrb(cpu_data_wstrb),
        .cpu_data_rdata(cpu_data_rdata), .cpu_data_addr_ok(cpu_data_addr_ok),
        .cpu_data_data_ok(cpu_data_data_ok),
        .sb_data_req(sb_data_req), .sb_data_addr(sb_data_addr),
        .sb_data_wdata(sb_data_wdata), .sb_data_wstrb(sb_data_wstrb),
        .sb_urgent(sb_urgent), .sb_data_addr_ok(sb_data_addr_ok),
        .sb_data_data_ok(sb_data_data_ok),
        .dcache_data_req(dcache_data_req), .dcache_data_wr(dcache_data_wr),
        .dcache_data_size(dcache_data_size), .dcache_data_addr(dcache_data_addr),
        .dcache_data_wdata(dcache_data_wdata), .dcache_data_wstrb(dcache_data_wstrb),
        .dcache_data_rdata(dcache_data_rdata), .dcache_data_addr_ok(dcache_data_addr_ok),
        .dcache_data_data_ok(dcache_data_data_ok)
    );

    function automatic logic [31:0] b2w(input logic b);
        return {31'd0, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
        cpu_data_addr = 32'd0; cpu_data_wdata = 32'd0; cpu_data_wstrb = 4'd0;
        sb_data_req = 1'b0; sb_urgent = 1'b0; sb_data_addr = 32'd0;
        sb_data_wdata = 32'd0; sb_data_wstrb = 4'd0;
        dcache_data_addr_ok = 1'b0; dcache_data_data_ok = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle, compare addr_ok against the step's expectation and data_ok against the scoreboard head.
    task automatic step(input string tag, input logic exp_cpu_aok, input logic exp_sb_aok);
        logic head;
        #2;
        chk({tag, ".cpu_addr_ok"}, b2w(cpu_data_addr_ok), b2w(exp_cpu_aok));
        chk({tag, ".sb_addr_ok"}, b2w(sb_data_addr_ok), b2w(exp_sb_aok));
        if (dcache_data_data_ok && (exp_owner_q.size() > 0)) begin
            head = exp_owner_q.pop_front();
            chk({tag, ".cpu_data_ok"}, b2w(cpu_data_data_ok), b2w(!head));
            chk({tag, ".sb_data_ok"}, b2w(sb_data_data_ok), b2w(head));
        end else begin
            chk({tag, ".cpu_data_ok_idle"}, b2w(cpu_data_data_ok), 32'd0);
            chk({tag, ".sb_data_ok_idle"}, b2w(sb_data_data_ok), 32'd0);
        end
        if (exp_cpu_aok) exp_owner_q.push_back(1'b0);
        if (exp_sb_aok) exp_owner_q.push_back(1'b1);
    endtask

    initial begin
        bit sb_turn;
        resetn = 1'b0;
        idle();
        dcache_data_rdata = 32'd0;
        #3;
        chk("rst.cpu_addr_ok", b2w(cpu_data_addr_ok), 32'd0);
        chk("rst.sb_addr_ok", b2w(sb_data_addr_ok), 32'd0);
        chk("rst.cpu_data_ok", b2w(cpu_data_data_ok), 32'd0);
        chk("rst.sb_data_ok", b2w(sb_data_data_ok), 32'd0);
        chk("rst.dcache_req", b2w(dcache_data_req), 32'd0);
        tick(); tick();
        resetn = 1'b1;

        // Single CPU read: accepted one cycle late, completed two cycles after acceptance.
        cpu_data_req = 1'b1; cpu_data_addr = 32'h0000_1000;
        step("rd_wait", 1'b0, 1'b0);
        chk("rd_wait.req", b2w(dcache_data_req), 32'd1);
        chk("rd_wait.addr", dcache_data_addr, 32'h0000_1000);
        chk("rd_wait.wr", b2w(dcache_data_wr), 32'd0);
        tick();
        dcache_data_addr_ok = 1'b1;
        step("rd_acc", 1'b1, 1'b0);
        tick();
        idle();
        step("rd_gap", 1'b0, 1'b0);
        tick();
        dcache_data_data_ok = 1'b1; dcache_data_rdata = 32'hDEAD_BEEF;
        step("rd_dok", 1'b0, 1'b0);
        chk("rd_dok.rdata", cpu_data_rdata, 32'hDEAD_BEEF);
        tick();
        idle();
        step("rd_quiet", 1'b0, 1'b0);
        tick();

        // Both requesters continuous: 8 CPU wins then one forced drain, twice.
        cpu_data_req = 1'b1; cpu_data_size = 2'd1; cpu_data_addr = 32'h0000_3000;
        sb_data_req = 1'b1; sb_data_addr = 32'h0000_4000;
        sb_data_wdata = 32'h5555_AAAA; sb_data_wstrb = 4'hF;
        dcache_data_addr_ok = 1'b1; dcache_data_data_ok = 1'b1;
        for (int i = 0; i < 18; i++) begin
            sb_turn = ((i % 9) == 8);
            step("starve", !sb_turn, sb_turn);
            if (sb_turn) begin
                chk("starve.sb_wr", b2w(dcache_data_wr), 32'd1);
                chk("starve.sb_size", {30'd0, dcache_data_size}, 32'd2);
                chk("starve.sb_addr", dcache_data_addr, 32'h0000_4000);
            end
            tick();
        end
        idle();
        dcache_data_data_ok = 1'b1;
        step("starve_drain", 1'b0, 1'b0);
        tick();

        // Urgent drain beats a simultaneous CPU request; completions return sb then cpu.
        idle();
        cpu_data_req = 1'b1; cpu_data_wr = 1'b1; cpu_data_addr = 32'h0000_5000;
        sb_data_req = 1'b1; sb_urgent = 1'b1; sb_data_addr = 32'h0000_6000;
        dcache_data_addr_ok = 1'b1;
        step("urg_sb", 1'b0, 1'b1);
        chk("urg_sb.addr", dcache_data_addr, 32'h0000_6000);
        tick();
        sb_data_req = 1'b0; sb_urgent = 1'b0;
        step("urg_cpu", 1'b1, 1'b0);
        chk("urg_cpu.addr", dcache_data_addr, 32'h0000_5000);
        tick();
        idle();
        dcache_data_data_ok = 1'b1;
        step("urg_dok1", 1'b0, 1'b0);
        tick();
        step("urg_dok2", 1'b0, 1'b0);
        tick();

        // Stalled CPU request stays locked even after an urgent drain appears.
        idle();
        cpu_data_req = 1'b1; cpu_data_addr = 32'h0000_2000;
        step("lock1", 1'b0, 1'b0);
        chk("lock1.addr", dcache_data_addr, 32'h0000_2000);
        tick();
        sb_data_req = 1'b1; sb_urgent = 1'b1; sb_data_addr = 32'h0000_7000;
        step("lock2", 1'b0, 1'b0);
        chk("lock2.addr", dcache_data_addr, 32'h0000_2000);
        tick();
        step("lock3", 1'b0, 1'b0);
        chk("lock3.addr", dcache_data_addr, 32'h0000_2000);
        tick();
        dcache_data_addr_ok = 1'b1;
        step("lock_acc", 1'b1, 1'b0);
        chk("lock_acc.addr", dcache_data_addr, 32'h0000_2000);
        tick();
        cpu_data_req = 1'b0;
        step("lock_sb", 1'b0, 1'b1);
        chk("lock_sb.addr", dcache_data_addr, 32'h0000_7000);
        tick();
        idle();
        dcache_data_data_ok = 1'b1;
        step("lock_dok1", 1'b0, 1'b0);
        tick();
        step("lock_dok2", 1'b0, 1'b0);
        tick();

        // Fill to the outstanding limit, then check blocking and the push/pop case.
        idle();
        cpu_data_req = 1'b1; cpu_data_addr = 32'h0000_8000; dcache_data_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("fill", 1'b1, 1'b0);
            tick();
        end
        step("full_blk", 1'b0, 1'b0);
        chk("full_blk.req", b2w(dcache_data_req), 32'd0);
        tick();
        dcache_data_data_ok = 1'b1;
        step("full_pop", 1'b0, 1'b0);
        chk("full_pop.req", b2w(dcache_data_req), 32'd0);
        tick();
        dcache_data_data_ok = 1'b0;
        step("full_free", 1'b1, 1'b0);
        tick();
        cpu_data_req = 1'b0; dcache_data_data_ok = 1'b1;
        step("to_two_a", 1'b0, 1'b0);
        tick();
        step("to_two_b", 1'b0, 1'b0);
        tick();
        cpu_data_req = 1'b1;
        step("pushpop", 1'b1, 1'b0);
        tick();
        dcache_data_data_ok = 1'b0;
        step("pp_fill_a", 1'b1, 1'b0);
        tick();
        step("pp_fill_b", 1'b1, 1'b0);
        tick();
        step("pp_full", 1'b0, 1'b0);
        chk("pp_full.req", b2w(dcache_data_req), 32'd0);
        tick();
        cpu_data_req = 1'b0; dcache_data_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("full_drain", 1'b0, 1'b0);
            tick();
        end

        // Asynchronous reset with three transactions outstanding.
        idle();
        cpu_data_req = 1'b1; cpu_data_addr = 32'h0000_9000; dcache_data_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("pre_rst", 1'b1, 1'b0);
            tick();
        end
        dcache_data_data_ok = 1'b1; dcache_data_rdata = 32'hCAFE_F00D;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst.cpu_addr_ok", b2w(cpu_data_addr_ok), 32'd0);
        chk("arst.sb_addr_ok", b2w(sb_data_addr_ok), 32'd0);
        chk("arst.cpu_data_ok", b2w(cpu_data_data_ok), 32'd0);
        chk("arst.sb_data_ok", b2w(sb_data_data_ok), 32'd0);
        chk("arst.dcache_req", b2w(dcache_data_req), 32'd0);
        chk("arst.rdata", cpu_data_rdata, 32'hCAFE_F00D);
        exp_owner_q.delete();
        tick(); tick();
        idle();
        resetn = 1'b1;
        dcache_data_data_ok = 1'b1;
        step("empty_dok", 1'b0, 1'b0);
        tick();
        idle();
        cpu_data_req = 1'b1; cpu_data_addr = 32'h0000_A000; dcache_data_addr_ok = 1'b1;
        step("post_rst_acc", 1'b1, 1'b0);
        tick();
        idle();
        dcache_data_data_ok = 1'b1; dcache_data_rdata = 32'h1234_5678;
        step("post_rst_dok", 1'b0, 1'b0);
        chk("post_rst_dok.rdata", cpu_data_rdata, 32'h1234_5678);
        tick();
        idle();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
